// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: FSM states, opcodes,
// mux/ALU encodings and the opcode -> instruction-class decode.
package ctrl_pkg;

   typedef enum logic [2:0] {
      RST    = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_e;

   localparam int unsigned OP_W = 7;

   localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_BR  = 2'b01;
   localparam logic [1:0] ALU_OP_R   = 2'b10;
   localparam logic [1:0] ALU_OP_I   = 2'b11;

   localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
   localparam logic [1:0] PC_SRC_IMM  = 2'd1;
   localparam logic [1:0] PC_SRC_JALR = 2'd2;

   localparam logic [1:0] WB_SRC_ALU = 2'd0;
   localparam logic [1:0] WB_SRC_MDR = 2'd1;
   localparam logic [1:0] WB_SRC_PC4 = 2'd2;
   localparam logic [1:0] WB_SRC_IMM = 2'd3;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
      CL_JAL, CL_JALR, CL_AUIPC, CL_LUI, CL_ILLEGAL
   } class_e;

   // Map a 7-bit major opcode to its instruction class.
   function automatic class_e op_class(input logic [OP_W-1:0] op);
      case (op)
         OP_R:      op_class = CL_R;
         OP_I:      op_class = CL_I;
         OP_LOAD:   op_class = CL_LOAD;
         OP_STORE:  op_class = CL_STORE;
         OP_BRANCH: op_class = CL_BRANCH;
         OP_JAL:    op_class = CL_JAL;
         OP_JALR:   op_class = CL_JALR;
         OP_AUIPC:  op_class = CL_AUIPC;
         OP_LUI:    op_class = CL_LUI;
         default:   op_class = CL_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared ALU and
// a single-port unified memory; traps on unknown opcodes; counts retirements.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   opcode            instr[6:0] from IR (valid from DECODE onward)
//   branch_taken      branch comparator result (EXEC)
//   mem_ready         memory completes the current access this cycle
//   pc_write, pc_src  PC load enable / PC source select
//   ir_write          IR load enable
//   mem_read_en, mem_write_en, addr_src   memory request and address select
//   alu_a_src, ALU_src, ALU_op            ALU operand selects and operation
//   wb_src, reg_write register-file write source / enable
//   illegal           sticky trap flag
//   retired           instructions completed since reset
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned RET_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             mem_read_en,
   output logic             mem_write_en,
   output logic             addr_src,
   output logic             alu_a_src,
   output logic             ALU_src,
   output logic [1:0]       ALU_op,
   output logic [1:0]       wb_src,
   output logic             reg_write,
   output logic             illegal,
   output logic [RET_W-1:0] retired
);

   state_e          state, state_nxt;
   logic [OP_W-1:0] opcode_q;
   class_e          cls_q;
   logic            retire_c;

   assign cls_q = op_class(opcode_q);

   // State register, latched opcode, sticky trap flag and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RST;
         opcode_q <= '0;
         illegal  <= 1'b0;
         retired  <= '0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) opcode_q <= opcode;
         if (state_nxt == TRAP) illegal <= 1'b1;
         if (retire_c) retired <= retired + RET_W'(1);
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nxt    = state;
      retire_c     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_SEQ;
      ir_write     = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      addr_src     = 1'b0;
      alu_a_src    = 1'b0;
      ALU_src      = 1'b0;
      ALU_op       = ALU_OP_ADD;
      wb_src       = WB_SRC_ALU;
      reg_write    = 1'b0;

      case (state)
         RST: state_nxt = FETCH;

         // Request stays asserted for the whole wait; IR loads on completion.
         FETCH: begin
            mem_read_en = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               state_nxt = DECODE;
            end
         end

         // Classify the live IR opcode; it is captured into opcode_q this cycle.
         DECODE: state_nxt = (op_class(opcode) == CL_ILLEGAL) ? TRAP : EXEC;

         EXEC: begin
            case (cls_q)
               CL_R: begin
                  ALU_op    = ALU_OP_R;
                  state_nxt = WB;
               end
               CL_I: begin
                  ALU_op    = ALU_OP_I;
                  ALU_src   = 1'b1;
                  state_nxt = WB;
               end
               CL_LOAD, CL_STORE: begin
                  ALU_src   = 1'b1;
                  state_nxt = MEM;
               end
               CL_AUIPC: begin
                  alu_a_src = 1'b1;
                  ALU_src   = 1'b1;
                  state_nxt = WB;
               end
               // Branches resolve and retire here; no register write.
               CL_BRANCH: begin
                  ALU_op    = ALU_OP_BR;
                  pc_write  = 1'b1;
                  pc_src    = branch_taken ? PC_SRC_IMM : PC_SRC_SEQ;
                  retire_c  = 1'b1;
                  state_nxt = FETCH;
               end
               CL_LUI, CL_JAL, CL_JALR: state_nxt = WB;
               default: state_nxt = TRAP;
            endcase
         end

         MEM: begin
            addr_src = 1'b1;
            if (cls_q == CL_STORE) mem_write_en = 1'b1;
            else                   mem_read_en  = 1'b1;
            if (mem_ready) begin
               if (cls_q == CL_STORE) begin
                  pc_write  = 1'b1;
                  retire_c  = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  state_nxt = WB;
               end
            end
         end

         WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire_c  = 1'b1;
            state_nxt = FETCH;
            case (cls_q)
               CL_LOAD:          wb_src = WB_SRC_MDR;
               CL_JAL, CL_JALR:  wb_src = WB_SRC_PC4;
               CL_LUI:           wb_src = WB_SRC_IMM;
               default:          wb_src = WB_SRC_ALU;
            endcase
            case (cls_q)
               CL_JAL:  pc_src = PC_SRC_IMM;
               CL_JALR: pc_src = PC_SRC_JALR;
               default: pc_src = PC_SRC_SEQ;
            endcase
         end

         // Parked until reset.
         TRAP: state_nxt = TRAP;

         default: state_nxt = RST;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each
// instruction class, memory stalls, reset during a wait, trap and counter wrap.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = '0;
   logic        branch_taken = 1'b0;
   logic        mem_ready = 1'b1;

   logic        pc_write, ir_write, mem_read_en, mem_write_en, addr_src;
   logic        alu_a_src, ALU_src, reg_write, illegal;
   logic [1:0]  pc_src, ALU_op, wb_src;
   logic [31:0] retired;

   logic        w_pc_write, w_ir_write, w_mem_read_en, w_mem_write_en, w_addr_src;
   logic        w_alu_a_src, w_ALU_src, w_reg_write, w_illegal;
   logic [1:0]  w_pc_src, w_ALU_op, w_wb_src;
   logic [2:0]  w_retired;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned exp_ret  = 0;

   logic [14:0] outs;
   logic [14:0] e;

   always #5 clk = ~clk;

   multicycle_ctrl #(.RET_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .addr_src(addr_src),
      .alu_a_src(alu_a_src), .ALU_src(ALU_src), .ALU_op(ALU_op), .wb_src(wb_src),
      .reg_write(reg_write), .illegal(illegal), .retired(retired)
   );

   // Narrow-counter instance used to observe wrap-around.
   multicycle_ctrl #(.RET_W(3)) dut_w (
      .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .pc_write(w_pc_write), .pc_src(w_pc_src), .ir_write(w_ir_write),
      .mem_read_en(w_mem_read_en), .mem_write_en(w_mem_write_en), .addr_src(w_addr_src),
      .alu_a_src(w_alu_a_src), .ALU_src(w_ALU_src), .ALU_op(w_ALU_op), .wb_src(w_wb_src),
      .reg_write(w_reg_write), .illegal(w_illegal), .retired(w_retired)
   );

   assign outs = {pc_write, pc_src, ir_write, mem_read_en, mem_write_en, addr_src,
                  alu_a_src, ALU_src, ALU_op, wb_src, reg_write, illegal};

   function automatic logic [14:0] ov(input logic pw, input logic [1:0] ps, input logic irw,
                                      input logic mr, input logic mw, input logic as,
                                      input logic aas, input logic als, input logic [1:0] aop,
                                      input logic [1:0] wbs, input logic rw, input logic ill);
      ov = {pw, ps, irw, mr, mw, as, aas, als, aop, wbs, rw, ill};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scenario 1: reset held three cycles during a stalled load MEM phase.
   task automatic test_reset();
      reset = 1'b1; opcode = OP_LOAD; mem_ready = 1'b1; branch_taken = 1'b0;
      tick(); tick();
      reset = 1'b0; #1;
      e = '0; n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL reset_rst outs=%b exp=%b", outs, e); end
      n_checks++;
      if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired); end
      tick(); // FETCH
      tick(); // DECODE
      tick(); // EXEC
      mem_ready = 1'b0;
      tick(); #1; // MEM, stalled
      e = ov(0,0,0,1,0,1,0,0,0,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL reset_memwait outs=%b exp=%b", outs, e); end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = '0; n_checks++;
         if (outs !== e || retired !== 32'd0) begin
            n_fail++; $display("FAIL reset_hold%0d outs=%b ret=%0d exp=%b ret=0", i, outs, retired, e);
         end
      end
      reset = 1'b0; exp_ret = 0; #1;
      e = '0; n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL reset_release outs=%b exp=%b", outs, e); end
      tick(); // FETCH, memory still busy
      e = ov(0,0,0,1,0,0,0,0,0,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL reset_fetch outs=%b exp=%b", outs, e); end
      mem_ready = 1'b1;
      // Finish this lw so later tests start cleanly in FETCH.
      tick(); tick(); tick(); tick(); tick();
      exp_ret++;
   endtask

   // Scenario 2: R-type add with no stalls.
   task automatic test_add();
      opcode = OP_R; mem_ready = 1'b1; #1;
      e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL add_fetch outs=%b exp=%b", outs, e); end
      tick();
      e = '0; n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL add_decode outs=%b exp=%b", outs, e); end
      tick();
      e = ov(0,0,0,0,0,0,0,0,2'b10,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL add_exec outs=%b exp=%b", outs, e); end
      tick();
      e = ov(1,0,0,0,0,0,0,0,0,0,1,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL add_wb outs=%b exp=%b", outs, e); end
      tick(); exp_ret++;
      e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
      if (outs !== e || retired !== exp_ret) begin
         n_fail++; $display("FAIL add_done outs=%b ret=%0d exp=%b ret=%0d", outs, retired, e, exp_ret);
      end
   endtask

   // Scenario 3: load with 2 fetch stalls and 3 memory stalls (10 cycles).
   task automatic test_load_stall();
      opcode = OP_LOAD; mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1; e = ov(0,0,0,1,0,0,0,0,0,0,0,0); n_checks++;
         if (outs !== e) begin n_fail++; $display("FAIL lw_fetchwait%0d outs=%b exp=%b", i, outs, e); end
         tick();
      end
      mem_ready = 1'b1; #1;
      e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL lw_fetch outs=%b exp=%b", outs, e); end
      tick(); tick();
      e = ov(0,0,0,0,0,0,0,1,0,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL lw_exec outs=%b exp=%b", outs, e); end
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         #1; e = ov(0,0,0,1,0,1,0,0,0,0,0,0); n_checks++;
         if (outs !== e) begin n_fail++; $display("FAIL lw_mem%0d outs=%b exp=%b", i, outs, e); end
         tick();
      end
      e = ov(1,0,0,0,0,0,0,0,0,2'd1,1,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL lw_wb outs=%b exp=%b", outs, e); end
      tick(); exp_ret++;
      e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
      if (outs !== e || retired !== exp_ret) begin
         n_fail++; $display("FAIL lw_done outs=%b ret=%0d exp=%b ret=%0d", outs, retired, e, exp_ret);
      end
   endtask

   // Scenario 4: beq taken then not taken, 3 cycles each.
   task automatic test_branch();
      for (int t = 1; t >= 0; t--) begin
         opcode = OP_BRANCH; mem_ready = 1'b1; branch_taken = 1'b0;
         tick(); tick();
         branch_taken = 1'(t); #1;
         e = ov(1, (t == 1) ? 2'd1 : 2'd0, 0,0,0,0,0,0,2'b01,0,0,0); n_checks++;
         if (outs !== e) begin n_fail++; $display("FAIL beq_exec_t%0d outs=%b exp=%b", t, outs, e); end
         tick(); exp_ret++;
         e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
         if (outs !== e || retired !== exp_ret) begin
            n_fail++; $display("FAIL beq_done_t%0d outs=%b ret=%0d exp=%b ret=%0d", t, outs, retired, e, exp_ret);
         end
      end
      branch_taken = 1'b0;
   endtask

   // Scenario 5: jalr write-back selects pc+4 and ALU target.
   task automatic test_jalr();
      opcode = OP_JALR; mem_ready = 1'b1;
      tick(); tick();
      e = '0; n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL jalr_exec outs=%b exp=%b", outs, e); end
      tick();
      e = ov(1,2'd2,0,0,0,0,0,0,0,2'd2,1,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL jalr_wb outs=%b exp=%b", outs, e); end
      tick(); exp_ret++;
      n_checks++;
      if (retired !== exp_ret) begin n_fail++; $display("FAIL jalr_retired got=%0d exp=%0d", retired, exp_ret); end
   endtask

   // Remaining classes issued back to back from a table.
   typedef struct {
      logic [6:0]  op;
      logic [14:0] ex;
      bit          has_mem;
      logic [14:0] mm;
      bit          has_wb;
      logic [14:0] wb;
   } vec_t;

   task automatic test_back_to_back();
      vec_t v [5];
      v[0] = '{OP_I,     ov(0,0,0,0,0,0,0,1,2'b11,0,0,0), 1'b0, '0, 1'b1, ov(1,0,0,0,0,0,0,0,0,2'd0,1,0)};
      v[1] = '{OP_STORE, ov(0,0,0,0,0,0,0,1,2'b00,0,0,0), 1'b1, ov(1,0,0,0,1,1,0,0,0,0,0,0), 1'b0, '0};
      v[2] = '{OP_JAL,   '0,                               1'b0, '0, 1'b1, ov(1,2'd1,0,0,0,0,0,0,0,2'd2,1,0)};
      v[3] = '{OP_AUIPC, ov(0,0,0,0,0,0,1,1,2'b00,0,0,0), 1'b0, '0, 1'b1, ov(1,0,0,0,0,0,0,0,0,2'd0,1,0)};
      v[4] = '{OP_LUI,   '0,                               1'b0, '0, 1'b1, ov(1,0,0,0,0,0,0,0,0,2'd3,1,0)};
      mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         opcode = v[k].op; #1;
         e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
         if (outs !== e) begin n_fail++; $display("FAIL b2b%0d_fetch outs=%b exp=%b", k, outs, e); end
         tick(); tick();
         n_checks++;
         if (outs !== v[k].ex) begin n_fail++; $display("FAIL b2b%0d_exec outs=%b exp=%b", k, outs, v[k].ex); end
         tick();
         if (v[k].has_mem) begin
            n_checks++;
            if (outs !== v[k].mm) begin n_fail++; $display("FAIL b2b%0d_mem outs=%b exp=%b", k, outs, v[k].mm); end
            if (!v[k].has_wb) tick();
         end
         if (v[k].has_wb) begin
            n_checks++;
            if (outs !== v[k].wb) begin n_fail++; $display("FAIL b2b%0d_wb outs=%b exp=%b", k, outs, v[k].wb); end
            tick();
         end
         exp_ret++;
         n_checks++;
         if (retired !== exp_ret) begin n_fail++; $display("FAIL b2b%0d_retired got=%0d exp=%0d", k, retired, exp_ret); end
      end
   endtask

   // Narrow counter wraps 7 -> 0 silently.
   task automatic test_wrap();
      opcode = OP_R; mem_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(); tick(); tick(); tick();
         exp_ret++;
         n_checks++;
         if (w_retired !== 3'(exp_ret) || retired !== exp_ret) begin
            n_fail++; $display("FAIL wrap%0d ret3=%0d ret32=%0d exp3=%0d exp32=%0d",
                               k, w_retired, retired, 3'(exp_ret), exp_ret);
         end
      end
   endtask

   // Scenario 6: unknown opcode parks in TRAP until reset.
   task automatic test_trap();
      opcode = 7'b1111111; mem_ready = 1'b1;
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'(i[0]); #1;
         e = ov(0,0,0,0,0,0,0,0,0,0,0,1); n_checks++;
         if (outs !== e || retired !== exp_ret) begin
            n_fail++; $display("FAIL trap%0d outs=%b ret=%0d exp=%b ret=%0d", i, outs, retired, e, exp_ret);
         end
         tick();
      end
      reset = 1'b1; tick(); reset = 1'b0; exp_ret = 0; #1;
      e = '0; n_checks++;
      if (outs !== e || retired !== 32'd0 || w_retired !== 3'd0) begin
         n_fail++; $display("FAIL trap_reset outs=%b ret=%0d ret3=%0d exp=%b ret=0", outs, retired, w_retired, e);
      end
      mem_ready = 1'b1;
      tick();
      e = ov(0,0,1,1,0,0,0,0,0,0,0,0); n_checks++;
      if (outs !== e) begin n_fail++; $display("FAIL trap_refetch outs=%b exp=%b", outs, e); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_stall();
      test_branch();
      test_jalr();
      test_back_to_back();
      test_wrap();
      test_trap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
